// File: rtl/truth_table_sweeper_pkg.sv
// Shared types and constants for the truth-table sweeper: FSM states, row geometry and
// error-counter saturation.
package truth_table_sweeper_pkg;

    localparam int unsigned ROWS     = 8;
    localparam int unsigned ROW_W    = 3;
    localparam int unsigned ERR_W    = 8;
    localparam int unsigned SETTLE_W = 4;
    localparam int unsigned LOOP_W   = 8;

    localparam logic [ERR_W-1:0] ERR_MAX = 8'hFF;

    typedef enum logic [2:0] {
        StIdle,
        StDrive,
        StSettle,
        StCapture,
        StDone
    } state_e;

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (v == ERR_MAX) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/settle_timer.sv
// Loadable down-counter with a zero flag; holds at zero rather than wrapping.
module settle_timer
    import truth_table_sweeper_pkg::*;
#(
    parameter int unsigned Width = SETTLE_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Drives all eight input rows of an external 3-input circuit, samples its output after a
// settle delay, and compares the captured truth table against a golden one.
module truth_table_sweeper
    import truth_table_sweeper_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned LOOPS         = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [ROWS-1:0]  expected,
    input  logic             f_in,
    output logic             A,
    output logic             B,
    output logic             C,
    output logic             busy,
    output logic             done,
    output logic [ROWS-1:0]  tt_word,
    output logic             match,
    output logic [ERR_W-1:0] err_count
);

    localparam logic [SETTLE_W-1:0] SettleLoad = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [LOOP_W-1:0]   LastLoop   = LOOP_W'(LOOPS - 1);
    localparam logic [ROW_W-1:0]    LastRow    = ROW_W'(ROWS - 1);

    state_e             state_q, state_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [LOOP_W-1:0]  loop_q, loop_d;
    logic [ROW_W-1:0]   abc_q, abc_d;
    logic [ROWS-1:0]    shadow_q, shadow_d;
    logic [ROWS-1:0]    tt_q, tt_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic               match_q, match_d;

    logic timer_load;
    logic timer_dec;
    logic timer_zero;

    settle_timer #(
        .Width (SETTLE_W)
    ) u_settle_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (timer_load),
        .load_val_i (SettleLoad),
        .dec_i      (timer_dec),
        .zero_o     (timer_zero)
    );

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        loop_d     = loop_q;
        abc_d      = abc_q;
        shadow_d   = shadow_q;
        tt_d       = tt_q;
        err_d      = err_q;
        match_d    = match_q;
        timer_load = 1'b0;
        timer_dec  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    row_d   = '0;
                    loop_d  = '0;
                    err_d   = '0;
                    match_d = 1'b0;
                    state_d = StDrive;
                end
            end
            StDrive: begin
                abc_d      = row_q;
                timer_load = 1'b1;
                state_d    = StSettle;
            end
            StSettle: begin
                if (timer_zero) begin
                    state_d = StCapture;
                end else begin
                    timer_dec = 1'b1;
                end
            end
            StCapture: begin
                shadow_d[row_q] = f_in;
                if (f_in != expected[row_q]) begin
                    err_d = sat_inc(err_q);
                end
                if (row_q == LastRow) begin
                    row_d = '0;
                    // Publish from shadow_d so the row-7 sample lands on the same edge.
                    tt_d  = shadow_d;
                    if (loop_q == LastLoop) begin
                        match_d = (tt_d == expected);
                        state_d = StDone;
                    end else begin
                        loop_d  = loop_q + 1'b1;
                        state_d = StDrive;
                    end
                end else begin
                    row_d   = row_q + 1'b1;
                    state_d = StDrive;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            row_q    <= '0;
            loop_q   <= '0;
            abc_q    <= '0;
            shadow_q <= '0;
            tt_q     <= '0;
            err_q    <= '0;
            match_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            loop_q   <= loop_d;
            abc_q    <= abc_d;
            shadow_q <= shadow_d;
            tt_q     <= tt_d;
            err_q    <= err_d;
            match_q  <= match_d;
        end
    end

    assign {A, B, C}  = abc_q;
    assign busy       = (state_q == StDrive) || (state_q == StSettle) || (state_q == StCapture);
    assign done       = (state_q == StDone);
    assign tt_word    = tt_q;
    assign match      = match_q;
    assign err_count  = err_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed and randomized checks of truth_table_sweeper across three parameterizations.
module tb_truth_table_sweeper;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n     [3];
    logic       start     [3];
    logic [7:0] expected  [3];
    logic       f_in      [3];
    logic       A         [3];
    logic       B         [3];
    logic       C         [3];
    logic       busy      [3];
    logic       done      [3];
    logic [7:0] tt_word   [3];
    logic       match     [3];
    logic [7:0] err_count [3];
    logic [7:0] circ      [3];

    int total  = 0;
    int passed = 0;

    // Behavioural circuits under sweep: a lookup table indexed by {A,B,C}.
    assign f_in[0] = circ[0][{A[0], B[0], C[0]}];
    assign f_in[1] = circ[1][{A[1], B[1], C[1]}];
    assign f_in[2] = circ[2][{A[2], B[2], C[2]}];

    truth_table_sweeper #(.SETTLE_CYCLES(2), .LOOPS(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n[0]), .start(start[0]), .expected(expected[0]), .f_in(f_in[0]),
        .A(A[0]), .B(B[0]), .C(C[0]), .busy(busy[0]), .done(done[0]), .tt_word(tt_word[0]),
        .match(match[0]), .err_count(err_count[0])
    );

    truth_table_sweeper #(.SETTLE_CYCLES(2), .LOOPS(3)) u_dut1 (
        .clk(clk), .rst_n(rst_n[1]), .start(start[1]), .expected(expected[1]), .f_in(f_in[1]),
        .A(A[1]), .B(B[1]), .C(C[1]), .busy(busy[1]), .done(done[1]), .tt_word(tt_word[1]),
        .match(match[1]), .err_count(err_count[1])
    );

    truth_table_sweeper #(.SETTLE_CYCLES(1), .LOOPS(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n[2]), .start(start[2]), .expected(expected[2]), .f_in(f_in[2]),
        .A(A[2]), .B(B[2]), .C(C[2]), .busy(busy[2]), .done(done[2]), .tt_word(tt_word[2]),
        .match(match[2]), .err_count(err_count[2])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int ref_latency(input int s, input int loops);
        return loops * 8 * (s + 2) + 1;
    endfunction

    function automatic int ref_err(input logic [7:0] tt, input logic [7:0] exp, input int loops);
        int n;
        n = $countones(tt ^ exp) * loops;
        return (n > 255) ? 255 : n;
    endfunction

    function automatic logic [2:0] abc(input int d);
        return {A[d], B[d], C[d]};
    endfunction

    // One start pulse on instance d, then check timing and results against the model.
    task automatic sweep(input int d, input int s, input int loops, input string tag);
        int lat;
        start[d] = 1'b1;
        @(negedge clk);
        start[d] = 1'b0;
        lat = 1;
        chk({tag, "_busy"}, busy[d], 1);
        while (!done[d] && lat < 2000) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, lat, ref_latency(s, loops));
        chk({tag, "_done"}, done[d], 1);
        chk({tag, "_busy_low"}, busy[d], 0);
        chk({tag, "_tt_word"}, tt_word[d], circ[d]);
        chk({tag, "_match"}, match[d], circ[d] == expected[d]);
        chk({tag, "_err"}, err_count[d], ref_err(circ[d], expected[d], loops));
        @(negedge clk);
        chk({tag, "_done_pulse"}, done[d], 0);
        chk({tag, "_abc_hold"}, abc(d), 3'd7);
    endtask

    initial begin
        int         cnt;
        int         pulses;
        int         pulse_at [$];
        logic [7:0] exp_now;
        int         want_err;
        logic [2:0] trace [1:30];
        logic       dtr   [1:30];

        for (int d = 0; d < 3; d++) begin
            rst_n[d]    = 1'b0;
            start[d]    = 1'b0;
            expected[d] = '0;
            circ[d]     = '0;
        end
        @(negedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("reset_outputs_d%0d", d),
                {A[d], B[d], C[d], busy[d], done[d], match[d], tt_word[d], err_count[d]}, 0);
        end
        for (int d = 0; d < 3; d++) rst_n[d] = 1'b1;

        // Minterms {2,3,4,6,7}
        circ[0] = 8'hDC; expected[0] = 8'hDC;
        sweep(0, 2, 1, "golden_dc");
        expected[0] = 8'hDD;
        sweep(0, 2, 1, "one_row_off");

        circ[1] = 8'h00; expected[1] = 8'hFF;
        sweep(1, 2, 3, "loops3_zero");

        for (int i = 0; i < 6; i++) begin
            circ[0] = 8'($urandom); expected[0] = (i == 2) ? circ[0] : 8'($urandom);
            sweep(0, 2, 1, $sformatf("rand_d0_%0d", i));
        end
        for (int i = 0; i < 2; i++) begin
            circ[1] = 8'($urandom); expected[1] = 8'($urandom);
            sweep(1, 2, 3, $sformatf("rand_d1_%0d", i));
        end

        // Golden table changed mid-sweep: only rows captured afterwards see the new value.
        circ[0] = 8'hDC; expected[0] = 8'hDC;
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        cnt = 0;
        while (abc(0) != 3'd5 && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        expected[0] = 8'h00;
        cnt = 0;
        while (!done[0] && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        want_err = 0;
        for (int r = 0; r < 8; r++) begin
            exp_now = (r < 5) ? 8'hDC : 8'h00;
            if (circ[0][r] != exp_now[r]) want_err++;
        end
        chk("midsweep_done", done[0], 1);
        chk("midsweep_err", err_count[0], want_err);
        chk("midsweep_match", match[0], 0);
        chk("midsweep_tt", tt_word[0], 8'hDC);
        @(negedge clk);

        // Reset during row-4 settle.
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        cnt = 0;
        while (abc(0) != 3'd4 && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        chk("abort_reached_row4", busy[0], 1);
        #1 rst_n[0] = 1'b0;
        #1;
        chk("abort_outputs_zero",
            {A[0], B[0], C[0], busy[0], done[0], match[0], tt_word[0], err_count[0]}, 0);
        @(negedge clk);
        rst_n[0] = 1'b1;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done[0] || busy[0]) pulses++;
        end
        chk("abort_stays_idle", pulses, 0);
        sweep(0, 2, 1, "after_abort");

        // Start held high: one sweep per IDLE visit, period is latency plus one IDLE cycle.
        start[0] = 1'b1;
        for (int i = 1; i <= 110; i++) begin
            @(negedge clk);
            if (done[0]) pulse_at.push_back(i);
        end
        start[0] = 1'b0;
        chk("held_pulse_count", pulse_at.size(), 3);
        for (int k = 0; k < pulse_at.size() && k < 3; k++) begin
            chk($sformatf("held_pulse_%0d", k), pulse_at[k],
                ref_latency(2, 1) + k * (ref_latency(2, 1) + 1));
        end
        cnt = 0;
        while ((busy[0] || done[0]) && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        chk("held_drain", busy[0] | done[0], 0);

        // SETTLE_CYCLES=1: each row is held for three cycles.
        circ[2] = 8'hA5; expected[2] = 8'hA5;
        start[2] = 1'b1;
        @(negedge clk);
        start[2] = 1'b0;
        trace[1] = abc(2);
        dtr[1]   = done[2];
        for (int i = 2; i <= 30; i++) begin
            @(negedge clk);
            trace[i] = abc(2);
            dtr[i]   = done[2];
        end
        for (int r = 0; r < 8; r++) begin
            chk($sformatf("step_row%0d_first", r), trace[2 + 3 * r], r);
            chk($sformatf("step_row%0d_last", r), trace[4 + 3 * r], r);
        end
        chk("step_no_early_done", dtr[24], 0);
        chk("step_done", dtr[25], 1);
        chk("step_done_pulse", dtr[26], 0);
        chk("step_tt", tt_word[2], 8'hA5);
        chk("step_match", match[2], 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/truth_table_sweeper.md
TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

Interface
REQ-001 The block SHALL have parameter SETTLE_CYCLES, default 2, giving the number of wait cycles after each input change before sampling (legal 1..15).
REQ-002 The block SHALL have parameter LOOPS, default 1, giving the number of full 8-row sweeps per start (legal 1..255).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  single-cycle request to begin a sweep; honoured only in IDLE.
REQ-006 expected  input  8  golden truth table, bit k = required function value for row k = {A,B,C}.
REQ-007 f_in  input  1  output of the 3-input combinational circuit under sweep.
REQ-008 A, B, C  output  1 each  registered drive to the circuit inputs; A is the MSB of the row index.
REQ-009 busy  output  1  high from the cycle after accepted start until the cycle DONE is entered.
REQ-010 done  output  1  one-cycle pulse when a sweep completes.
REQ-011 tt_word  output  8  captured truth table of the last completed loop; bit k = f_in sampled at row k.
REQ-012 match  output  1  tt_word == expected; valid while done=1 and held until the next start.
REQ-013 err_count  output  8  number of mismatching rows accumulated over all loops of the current sweep; saturates at 255.

Function
REQ-014 The FSM SHALL have states IDLE, DRIVE, SETTLE, CAPTURE, and DONE.
REQ-015 IDLE -> DRIVE on start=1; the row counter clears to 0; the loop counter clears to 0; err_count clears to 0.
REQ-016 DRIVE SHALL register {A,B,C} = row, load the settle counter with SETTLE_CYCLES-1, and go to SETTLE next cycle.
REQ-017 SETTLE SHALL decrement the settle counter each cycle and go to CAPTURE when it reaches 0.
REQ-018 CAPTURE SHALL write f_in into tt_shadow[row] and increment err_count (saturating) if f_in != expected[row].
REQ-019 After CAPTURE, if row < 7 the block SHALL increment row and go to DRIVE; if row == 7 the row index wraps to 0.
REQ-020 At the end of a loop (row 7 captured), tt_word SHALL load tt_shadow including the row-7 bit in the same edge.
REQ-021 If further loops remain, the block SHALL go to DRIVE; otherwise it SHALL go to DONE.
REQ-022 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-023 Latency from accepted start to done SHALL be exactly LOOPS*8*(SETTLE_CYCLES+2)+1 cycles.
REQ-024 start while busy or in DONE SHALL be ignored, with no restart and no counter change.
REQ-025 start in the same cycle as the done pulse SHALL be ignored; the earliest accepted restart is the following IDLE cycle.
REQ-026 expected SHALL be sampled per row at CAPTURE, so changes mid-sweep affect only later rows.
REQ-027 A, B, C SHALL hold their last driven value in IDLE and DONE.
REQ-028 match SHALL compare against expected as sampled at DONE entry.

Reset
REQ-029 rst_n=0 SHALL force state IDLE and clear A, B, C, busy, done, match, tt_word, err_count, and all counters to 0, regardless of clk.
REQ-030 Reset asserted mid-sweep SHALL abort with no done pulse; after release the block waits in IDLE for start.
REQ-031 Reset SHALL release synchronously to clk at the integration level; the block itself SHALL require no extra cycle before accepting start.

Structure
REQ-032 A shared package SHALL hold the state enumeration, ROWS=8, ROW_W=3, and the err_count saturation constant.
REQ-033 The block SHALL contain one sub-module, settle_timer: a loadable down-counter with a zero flag.
REQ-034 The circuit under sweep SHALL be instantiated outside this block; the two are connected only through A, B, C, and f_in.

Verification
REQ-035 The bench SHALL cover: circuit with minterms {2,3,4,6,7}, expected=8'hDC, start pulse -> tt_word=8'hDC, match=1, err_count=0, done one cycle after 32 cycles (SETTLE_CYCLES=2).
REQ-036 The bench SHALL cover: same circuit, expected=8'hDD -> match=0, err_count=1, with tt_word still 8'hDC.
REQ-037 The bench SHALL cover: LOOPS=3 with f_in forced to constant 0 and expected=8'hFF -> err_count=24, done at cycle 97.
REQ-038 The bench SHALL cover: rst_n pulsed low during row 4 SETTLE -> all outputs 0 immediately and no done; a fresh start then completes normally.
REQ-039 The bench SHALL cover: start held high throughout -> exactly one sweep per IDLE entry, with no start accepted while busy or on the done cycle.
REQ-040 The bench SHALL cover: SETTLE_CYCLES=1 -> {A,B,C} steps 000 to 111 every 3 cycles, then done.
